// File: rtl/sr_input_sequencer.sv
// Button-to-pulse sequencer for the gate-level SR latch: sync, debounce, edge-detect, then S/R pulse FSM.
// Build option: define SR_SEQ_DEBOUNCE_EN to include the per-button debounce counters.
module sr_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic busy,
  output logic q_expect,
  output logic conflict,
  output logic overrun
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_deb_range
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_pulse_range
    $error("PULSE_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_DRIVE_S,
    ST_DRIVE_R,
    ST_GUARD
  } state_t;

  // Channel 0 is the set button, channel 1 the reset button.
  logic [1:0] btn_raw;
  logic [1:0] req;

  assign btn_raw = {btn_rst, btn_set};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic sync1_reg;
      logic sync2_reg;
      logic deb;
      logic deb_prev_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_prev_reg <= 1'b0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb;
        end
      end

`ifdef SR_SEQ_DEBOUNCE_EN
      logic       deb_reg;
      logic [7:0] cnt_reg;

      // The level only moves after DEBOUNCE_CYCLES consecutive mismatching samples.
      always_ff @(posedge clk) begin
        if (rst) begin
          deb_reg <= 1'b0;
          cnt_reg <= 8'd0;
        end else if (sync2_reg != deb_reg) begin
          if (cnt_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= sync2_reg;
            cnt_reg <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end else begin
          cnt_reg <= 8'd0;
        end
      end

      assign deb = deb_reg;
`else
      assign deb = sync2_reg;
`endif

      assign req[gi] = deb & ~deb_prev_reg;
    end
  endgenerate

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] pcnt_reg;
  logic [7:0] pcnt_next;

  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_INIT;
        pcnt_next  = 8'd0;
      end
      ST_INIT, ST_DRIVE_S, ST_DRIVE_R: begin
        if (pcnt_reg == 8'(PULSE_CYCLES - 1)) begin
          state_next = ST_GUARD;
          pcnt_next  = 8'd0;
        end else begin
          pcnt_next = pcnt_reg + 8'd1;
        end
      end
      ST_IDLE: begin
        pcnt_next = 8'd0;
        if (req[0] && !req[1]) begin
          state_next = ST_DRIVE_S;
        end else if (req[1] && !req[0]) begin
          state_next = ST_DRIVE_R;
        end
      end
      ST_GUARD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_RESET;
        pcnt_next  = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RESET;
      pcnt_reg  <= 8'd0;
      S         <= 1'b0;
      R         <= 1'b0;
      busy      <= 1'b0;
      q_expect  <= 1'b0;
      conflict  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
      S         <= (state_next == ST_DRIVE_S);
      R         <= (state_next == ST_DRIVE_R) || (state_next == ST_INIT);
      busy      <= (state_next == ST_INIT) || (state_next == ST_DRIVE_S) ||
                   (state_next == ST_DRIVE_R) || (state_next == ST_GUARD);
      if (state_next == ST_GUARD) begin
        q_expect <= (state_reg == ST_DRIVE_S);
      end
      conflict  <= (state_reg == ST_IDLE) && req[0] && req[1];
      overrun   <= (state_reg != ST_IDLE) && (req[0] || req[1]);
    end
  end

endmodule

// File: tb/tb_sr_input_sequencer.sv
// Directed bench for sr_input_sequencer; expected timing adapts to SR_SEQ_DEBOUNCE_EN.
module tb_sr_input_sequencer;

  localparam int DEB   = 4;
  localparam int PULSE = 2;
`ifdef SR_SEQ_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_set;
  logic btn_rst;
  logic S, R, busy, q_expect, conflict, overrun;

  int checks   = 0;
  int failures = 0;

  sr_input_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PULSE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_set (btn_set),
    .btn_rst (btn_rst),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .q_expect(q_expect),
    .conflict(conflict),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn_set = 1'b0; btn_rst = 1'b0;
    tick(3);
    check("rst_S", S, 1'b0);
    check("rst_R", R, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_q", q_expect, 1'b0);
    check("rst_conflict", conflict, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    $display("txn reset_hold S=%b R=%b busy=%b q=%b", S, R, busy, q_expect);

    // Reset release: INIT R pulse, guard, idle.
    rst = 1'b0;
    tick(1);
    check("init_e1_R", R, 1'b1); check("init_e1_busy", busy, 1'b1); check("init_e1_S", S, 1'b0);
    tick(1);
    check("init_e2_R", R, 1'b1); check("init_e2_S", S, 1'b0);
    tick(1);
    check("init_guard_R", R, 1'b0); check("init_guard_busy", busy, 1'b1);
    tick(1);
    check("init_idle_busy", busy, 1'b0); check("init_idle_q", q_expect, 1'b0);
    $display("txn reset_release R_pulse busy=%b q=%b", busy, q_expect);

    // Clean set press.
    btn_set = 1'b1;
    tick(LAT - 1);
    check("set_pre_S", S, 1'b0);
    tick(1);
    check("set_e1_S", S, 1'b1); check("set_e1_R", R, 1'b0); check("set_e1_busy", busy, 1'b1);
    tick(1);
    check("set_e2_S", S, 1'b1); check("set_e2_R", R, 1'b0);
    tick(1);
    check("set_guard_S", S, 1'b0); check("set_guard_busy", busy, 1'b1); check("set_guard_q", q_expect, 1'b1);
    tick(1);
    check("set_idle_busy", busy, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check("set_hold_S", S, 1'b0);
      check("set_hold_R", R, 1'b0);
    end
    $display("txn set_press S_pulse q=%b", q_expect);
    btn_set = 1'b0;
    tick(12);

`ifdef SR_SEQ_DEBOUNCE_EN
    // Bounce: 3 high samples, 1 low, then stable high.
    btn_set = 1'b1; tick(3);
    btn_set = 1'b0; tick(1);
    btn_set = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick(1);
      check("bounce_pre_S", S, 1'b0);
    end
    tick(1);
    check("bounce_e1_S", S, 1'b1);
    tick(1);
    check("bounce_e2_S", S, 1'b1);
    tick(1);
    check("bounce_end_S", S, 1'b0);
    tick(10);
    check("bounce_single_S", S, 1'b0);
    $display("txn bounce_press single S pulse");
    btn_set = 1'b0;
    tick(12);
`endif

    // Reset button press clears the shadow.
    btn_rst = 1'b1;
    tick(LAT);
    check("rbtn_e1_R", R, 1'b1); check("rbtn_e1_S", S, 1'b0);
    tick(1);
    check("rbtn_e2_R", R, 1'b1);
    tick(1);
    check("rbtn_guard_R", R, 1'b0); check("rbtn_guard_q", q_expect, 1'b0);
    $display("txn rst_press R_pulse q=%b", q_expect);
    btn_rst = 1'b0;
    tick(12);

    // Simultaneous press in IDLE.
    btn_set = 1'b1; btn_rst = 1'b1;
    tick(LAT);
    check("conf_pulse", conflict, 1'b1);
    check("conf_S", S, 1'b0); check("conf_R", R, 1'b0); check("conf_busy", busy, 1'b0);
    tick(1);
    check("conf_clear", conflict, 1'b0);
    check("conf_S2", S, 1'b0); check("conf_R2", R, 1'b0); check("conf_busy2", busy, 1'b0);
    $display("txn conflict conflict_pulse_seen");
    btn_set = 1'b0; btn_rst = 1'b0;
    tick(12);

    // Reset request lands during DRIVE_S.
    btn_set = 1'b1;
    tick(1);
    btn_rst = 1'b1;
    tick(LAT - 1);
    check("ovr_e1_S", S, 1'b1); check("ovr_e1_flag", overrun, 1'b0);
    tick(1);
    check("ovr_flag", overrun, 1'b1); check("ovr_S2", S, 1'b1); check("ovr_R", R, 1'b0);
    tick(1);
    check("ovr_clear", overrun, 1'b0); check("ovr_q", q_expect, 1'b1); check("ovr_guard_R", R, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("ovr_noR", R, 1'b0);
    end
    $display("txn overrun q=%b", q_expect);
    btn_set = 1'b0; btn_rst = 1'b0;
    tick(12);

    // Reset asserted in the second S cycle.
    btn_set = 1'b1;
    tick(LAT);
    check("mid_e1_S", S, 1'b1);
    tick(1);
    check("mid_e2_S", S, 1'b1);
    rst = 1'b1; btn_set = 1'b0;
    tick(1);
    check("mid_rst_S", S, 1'b0); check("mid_rst_R", R, 1'b0); check("mid_rst_q", q_expect, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("mid_init_R", R, 1'b1); check("mid_init_S", S, 1'b0);
    tick(1);
    check("mid_init_R2", R, 1'b1);
    tick(1);
    check("mid_guard_R", R, 1'b0); check("mid_guard_q", q_expect, 1'b0);
    tick(1);
    check("mid_idle_busy", busy, 1'b0);
    $display("txn reset_mid_pulse q=%b", q_expect);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
